// File: rtl/sobel_edge_stage.sv
// ============================================================================
// Module   : sobel_edge_stage
// Brief    : Streaming 3x3 Sobel gradient magnitude and binary edge detector
//            with two line buffers and a fixed 3-cycle latency.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sobel_edge_stage #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int THRESH = 100
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       VSYNC,
    input  logic       HSYNC,
    input  logic       DE,
    input  logic [7:0] DATA_IN,
    output logic       OUT_VSYNC,
    output logic       OUT_HSYNC,
    output logic       OUT_DE,
    output logic [7:0] MAG,
    output logic [7:0] EDGE,
    output logic       FRAME_DONE
);

    localparam int          c_aw       = $clog2(WIDTH);
    localparam logic [10:0] c_col_last = 11'(WIDTH - 1);
    localparam logic [9:0]  c_row_last = 10'(HEIGHT - 1);
    localparam logic [7:0]  c_thresh   = 8'(THRESH);

    logic [10:0]     r_col;
    logic [9:0]      r_row;
    logic            r_frame_end;
    logic [7:0]      r_lb1 [WIDTH];
    logic [7:0]      r_lb2 [WIDTH];
    logic [7:0]      r_win [3][3];
    logic            r_s1_valid, r_s1_last;
    logic            r_s2_valid, r_s2_last;
    logic signed [10:0] r_s2_gx, r_s2_gy;
    logic [2:0]      r_sync_s1, r_sync_s2;

    logic            w_adv;
    logic [c_aw-1:0] w_addr;
    logic [7:0]      w_lb1, w_lb2;
    logic [9:0]      w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic [10:0]     w_abs_gx, w_abs_gy, w_sum;
    logic [7:0]      w_mag;

    assign w_adv  = DE && !VSYNC;
    assign w_addr = r_col[c_aw-1:0];
    assign w_lb1  = r_lb1[w_addr];
    assign w_lb2  = r_lb2[w_addr];

    // Counters park at 0 after the last pixel until the next VSYNC.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_col       <= '0;
            r_row       <= '0;
            r_frame_end <= 1'b0;
        end else if (VSYNC) begin
            r_col       <= '0;
            r_row       <= '0;
            r_frame_end <= 1'b0;
        end else if (DE && !r_frame_end) begin
            if (r_col == c_col_last) begin
                r_col <= '0;
                if (r_row == c_row_last) begin
                    r_row       <= '0;
                    r_frame_end <= 1'b1;
                end else begin
                    r_row <= r_row + 10'd1;
                end
            end else begin
                r_col <= r_col + 11'd1;
            end
        end
    end

    // Line buffers carry no reset; border masking hides their stale contents.
    always_ff @(posedge HCLK) begin
        if (!HRESET && w_adv) begin
            r_lb2[w_addr] <= w_lb1;
            r_lb1[w_addr] <= DATA_IN;
        end
    end

    // Stage 1: window shift and border flag.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win[r][c] <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= w_adv && (r_row >= 10'd2) && (r_col >= 11'd2);
            r_s1_last  <= w_adv && !r_frame_end &&
                          (r_row == c_row_last) && (r_col == c_col_last);
            if (VSYNC) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        r_win[r][c] <= '0;
            end else if (DE) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_lb2;
                r_win[1][2] <= w_lb1;
                r_win[2][2] <= DATA_IN;
            end
        end
    end

    assign w_gx_pos = {2'b00, r_win[0][2]} + {1'b0, r_win[1][2], 1'b0} + {2'b00, r_win[2][2]};
    assign w_gx_neg = {2'b00, r_win[0][0]} + {1'b0, r_win[1][0], 1'b0} + {2'b00, r_win[2][0]};
    assign w_gy_pos = {2'b00, r_win[2][0]} + {1'b0, r_win[2][1], 1'b0} + {2'b00, r_win[2][2]};
    assign w_gy_neg = {2'b00, r_win[0][0]} + {1'b0, r_win[0][1], 1'b0} + {2'b00, r_win[0][2]};

    // Stage 2: signed gradients.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_s2_gx    <= '0;
            r_s2_gy    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else begin
            r_s2_gx    <= $signed({1'b0, w_gx_pos}) - $signed({1'b0, w_gx_neg});
            r_s2_gy    <= $signed({1'b0, w_gy_pos}) - $signed({1'b0, w_gy_neg});
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
        end
    end

    assign w_abs_gx = r_s2_gx[10] ? $unsigned(-r_s2_gx) : $unsigned(r_s2_gx);
    assign w_abs_gy = r_s2_gy[10] ? $unsigned(-r_s2_gy) : $unsigned(r_s2_gy);
    assign w_sum    = w_abs_gx + w_abs_gy;
    assign w_mag    = (|w_sum[10:8]) ? 8'hFF : w_sum[7:0];

    // Stage 3 plus the matching sync delay line.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sync_s1  <= '0;
            r_sync_s2  <= '0;
            OUT_VSYNC  <= 1'b0;
            OUT_HSYNC  <= 1'b0;
            OUT_DE     <= 1'b0;
            MAG        <= '0;
            EDGE       <= '0;
            FRAME_DONE <= 1'b0;
        end else begin
            r_sync_s1  <= {VSYNC, HSYNC, DE};
            r_sync_s2  <= r_sync_s1;
            {OUT_VSYNC, OUT_HSYNC, OUT_DE} <= r_sync_s2;
            MAG        <= r_s2_valid ? w_mag : 8'd0;
            EDGE       <= (r_s2_valid && (w_mag >= c_thresh)) ? 8'hFF : 8'd0;
            FRAME_DONE <= r_s2_last;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sobel_edge_stage.sv
// ============================================================================
// Module   : tb_sobel_edge_stage
// Brief    : Scoreboard bench for sobel_edge_stage using a direct image model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sobel_edge_stage;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct packed {
        logic [7:0] mag;
        logic [7:0] e100;
        logic [7:0] e80;
        logic       done;
    } exp_t;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic       VSYNC = 1'b0, HSYNC = 1'b0, DE = 1'b0;
    logic [7:0] DATA_IN = 8'd0;

    logic       ov, oh, ode, fd;
    logic [7:0] mag, edg;
    logic       ov80, oh80, ode80, fd80;
    logic [7:0] mag80, edg80;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [2:0] hist [4] = '{default: 3'b000};

    always #5 HCLK = ~HCLK;

    sobel_edge_stage #(.WIDTH(W), .HEIGHT(H), .THRESH(100)) u_dut (
        .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC), .DE(DE),
        .DATA_IN(DATA_IN), .OUT_VSYNC(ov), .OUT_HSYNC(oh), .OUT_DE(ode),
        .MAG(mag), .EDGE(edg), .FRAME_DONE(fd)
    );

    sobel_edge_stage #(.WIDTH(W), .HEIGHT(H), .THRESH(80)) u_dut80 (
        .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC), .DE(DE),
        .DATA_IN(DATA_IN), .OUT_VSYNC(ov80), .OUT_HSYNC(oh80), .OUT_DE(ode80),
        .MAG(mag80), .EDGE(edg80), .FRAME_DONE(fd80)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            0:       return 77;
            1:       return (c < 4) ? 0 : 200;
            default: return 10 * c;
        endcase
    endfunction

    // Result for input pixel (r,c): Sobel centred at (r-1,c-1) of the image.
    function automatic exp_t model(input int pat, input int r, input int c);
        exp_t e;
        int gx, gy, s;
        e = '0;
        e.done = (r == H - 1) && (c == W - 1);
        if (r >= 2 && c >= 2) begin
            gx = (pix(pat, r-2, c) + 2*pix(pat, r-1, c) + pix(pat, r, c))
               - (pix(pat, r-2, c-2) + 2*pix(pat, r-1, c-2) + pix(pat, r, c-2));
            gy = (pix(pat, r, c-2) + 2*pix(pat, r, c-1) + pix(pat, r, c))
               - (pix(pat, r-2, c-2) + 2*pix(pat, r-2, c-1) + pix(pat, r-2, c));
            s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            if (s > 255) s = 255;
            e.mag  = 8'(s);
            e.e100 = (s >= 100) ? 8'hFF : 8'h00;
            e.e80  = (s >= 80)  ? 8'hFF : 8'h00;
        end
        return e;
    endfunction

    task automatic drive(input logic vs, input logic hs, input logic de,
                         input logic rst, input logic [7:0] d);
        @(posedge HCLK);
        #1;
        VSYNC = vs; HSYNC = hs; DE = de; HRESET = rst; DATA_IN = d;
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {ov, oh, ode, fd, mag, edg, ov80, oh80, ode80, fd80, mag80, edg80}, 32'd0);
    endtask

    task automatic run_frame(input int pat, input int hgap, input int vgap, input int abort_at);
        for (int i = 0; i < vgap; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r * W + c == abort_at) begin
                    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
                    @(posedge HCLK);
                    #1;
                    HRESET = 1'b0;
                    sb.delete();
                    check_all_zero("post_reset_zero");
                    return;
                end
                drive(1'b0, 1'b0, 1'b1, 1'b0, 8'(pix(pat, r, c)));
                sb.push_back(model(pat, r, c));
            end
            for (int g = 0; g < hgap; g++) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        end
    endtask

    // Output monitor: sync delay line against input history, pixels against scoreboard.
    always @(negedge HCLK) begin
        exp_t e;
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = {VSYNC, HSYNC, DE};
        chk("sync_delay", {29'd0, ov, oh, ode}, {29'd0, hist[3]});
        chk("sync_delay80", {29'd0, ov80, oh80, ode80}, {29'd0, hist[3]});
        if (ode) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("mag", {24'd0, mag}, {24'd0, e.mag});
                chk("edge_t100", {24'd0, edg}, {24'd0, e.e100});
                chk("mag_t80", {24'd0, mag80}, {24'd0, e.mag});
                chk("edge_t80", {24'd0, edg80}, {24'd0, e.e80});
                chk("frame_done", {30'd0, fd, fd80}, {30'd0, e.done, e.done});
            end
        end else begin
            chk("idle_zero", {mag, edg, mag80, edg80}, 32'd0);
            chk("idle_done", {30'd0, fd, fd80}, 32'd0);
        end
        if (HRESET) begin
            hist[0] = 3'b000;
            hist[1] = 3'b000;
            hist[2] = 3'b000;
        end
    end

    initial begin
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        check_all_zero("reset_state");
        HRESET = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        run_frame(0, 0, 1, -1);     // flat
        run_frame(1, 0, 1, -1);     // vertical step
        run_frame(2, 0, 1, -1);     // horizontal ramp
        run_frame(1, 160, 100, -1); // reader-style blanking
        run_frame(1, 0, 1, -1);     // back-to-back step then flat
        run_frame(0, 0, 1, -1);
        run_frame(0, 0, 1, 3 * W + 5);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        run_frame(0, 0, 1, -1);

        repeat (10) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sobel_edge_stage.md
Name: sobel_edge_stage

Overview:
- Streaming 3x3 Sobel edge detector that sits directly downstream of the BMP image reader.
- Consumes its raster stream (VSYNC/HSYNC/DE plus an 8-bit grayscale pixel) and produces a gradient-magnitude stream and a thresholded binary edge stream.
- Output feeds the lane-detection / image-write stage.
- Two on-chip line buffers; no frame storage.

Parameters:
- WIDTH, 768, active pixels per line.
- HEIGHT, 512, active lines per frame.
- THRESH, 100, edge threshold on saturated magnitude, 8 bits.

Ports:
- HCLK  in  1  system clock, all logic on rising edge
- HRESET  in  1  synchronous active-high reset
- VSYNC  in  1  frame sync from reader, high during start-up delay
- HSYNC  in  1  line sync from reader, passed through
- DE  in  1  input pixel valid
- DATA_IN  in  8  grayscale pixel; wired to reader DATA_G, all channels equal
- OUT_VSYNC  out  1  VSYNC delayed 3 cycles
- OUT_HSYNC  out  1  HSYNC delayed 3 cycles
- OUT_DE  out  1  DE delayed 3 cycles
- MAG  out  8  saturated |Gx|+|Gy|
- EDGE  out  8  255 if MAG>=THRESH, else 0
- FRAME_DONE  out  1  one-cycle pulse with output of last pixel of frame

Behaviour:
- Reset, when HRESET is high at a clock edge:
  - All outputs 0.
  - Row/col counters 0.
  - Window registers and delay pipeline cleared.
  - Line-buffer contents undefined; border masking makes them irrelevant.
  - Reset mid-frame aborts the frame; the stream restarts at the next VSYNC.
- Counters:
  - col (11b) and row (10b) advance only on DE cycles.
  - col wraps WIDTH-1 -> 0, and row increments on that wrap.
  - VSYNC high forces row=col=0 and clears the window; this overrides DE in the same cycle.
  - After row HEIGHT-1 / col WIDTH-1 the counters hold at 0 until the next VSYNC. Extra DE pixels are processed as row 0 and produce zero output.
- Line buffers:
  - LB1 holds row-1 and LB2 holds row-2, each indexed by col.
  - On a DE cycle, read LB1[col] and LB2[col] first (old data), then write LB2[col]<=LB1[col] and LB1[col]<=DATA_IN.
- Window:
  - 3x3 shift register p[r][c]; r=0 is oldest row, c=0 is oldest column.
  - On DE, each row shifts left and new column = {LB2[col], LB1[col], DATA_IN}.
  - The window is not cleared at line start; border masking covers stale columns.
- Pipeline, 3 stages, latency exactly 3 HCLK from the DE cycle to the corresponding OUT_DE cycle:
  - S1: window update and capture of border flag valid = (row>=2 && col>=2).
  - S2: Gx = (p02+2p12+p22)-(p00+2p10+p20), Gy = (p20+2p21+p22)-(p00+2p01+p02). Both signed 11-bit, range ±1020.
  - S3: sum = |Gx|+|Gy| (11b unsigned, max 2040), MAG = min(sum,255), EDGE = (MAG>=THRESH)?255:0. If !valid, then MAG=EDGE=0.
  - Sync signals and DE pass through the same 3-stage delay. MAG/EDGE are 0 whenever OUT_DE=0.
- Geometry:
  - Output pixel k of the frame is the Sobel result centred at input (row-1, col-1) of input pixel k.
  - The output image is therefore the edge map shifted +1,+1: first two rows and columns are 0, and the last input row/column are never centres.
  - Exactly WIDTH*HEIGHT OUT_DE cycles are produced per complete frame.
- FRAME_DONE asserts for 1 cycle, coincident with the OUT_DE of input (HEIGHT-1, WIDTH-1).
- Gaps: DE low between pixels (HSYNC blanking) stalls counters and window but not the delay pipeline; outputs during gaps have OUT_DE=0.

Test Plan (WIDTH=8, HEIGHT=6, THRESH=100 unless stated):
- Flat frame, all pixels 77 -> all 48 OUT_DE cycles have MAG=0, EDGE=0; FRAME_DONE once, on the 48th OUT_DE; first OUT_DE exactly 3 cycles after first DE.
- Vertical step, pixel=0 for col<4 and 200 for col>=4 -> valid centres at col 3 and 4 give Gx=800, so MAG=255, EDGE=255; other valid centres give 0; rows 0-1 and cols 0-1 of output are 0.
- Horizontal ramp, pixel=10*col -> every valid output MAG=80, EDGE=0; rerun with THRESH=80 -> EDGE=255.
- Reader-style timing, 160-cycle HSYNC gaps between lines and 100-cycle VSYNC before the frame -> output identical to the gapless run; OUT_HSYNC/OUT_VSYNC equal the inputs delayed by 3 cycles.
- Two back-to-back frames, vertical step then flat -> frame 2 all zero, with no bleed from frame 1 line buffers into rows 0-1.
- HRESET asserted at row 3 col 5 for 1 cycle -> next cycle all outputs 0; a following VSYNC and full flat frame gives a correct result with FRAME_DONE once.
